// File: rtl/cmp_share_sched.sv
// Round-robin scheduler sharing one registered magnitude comparator among NREQ
// requesters through a two-stage (capture, compare) valid/ready pipeline.
module cmp_share_sched #(
   parameter int unsigned NREQ  = 4,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   input  logic [NREQ*3-1:0]     req_op,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic                  rsp_result,
   output logic                  rsp_eq,
   output logic                  busy,
   output logic [31:0]           done_cnt
);

   typedef enum logic [2:0] {
      OP_GTU = 3'd0, OP_GTS = 3'd1, OP_LTU = 3'd2, OP_LTS = 3'd3,
      OP_GEU = 3'd4, OP_GES = 3'd5, OP_LEU = 3'd6, OP_LES = 3'd7
   } cmp_op_e;

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   gnt_idx, cand;
   logic             gnt_found, hs;
   logic             s1_accept, s2_accept;

   logic             s1_v_q;
   logic [WIDTH-1:0] s1_a_q, s1_b_q;
   cmp_op_e          s1_op_q;
   logic [IDW-1:0]   s1_id_q;

   logic             rsp_valid_q, rsp_result_q, rsp_eq_q;
   logic [IDW-1:0]   rsp_id_q;
   logic [31:0]      done_cnt_q;

   logic [WIDTH-1:0] cmp_a, cmp_b;
   logic             cmp_lt, cmp_eq, cmp_res;

   assign s2_accept = !rsp_valid_q || rsp_ready;
   assign s1_accept = !s1_v_q || s2_accept;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr_q) + k) % NREQ);
         if (!gnt_found && req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   assign hs        = gnt_found && s1_accept && rst_n;
   assign req_ready = hs ? (NREQ'(1) << gnt_idx) : '0;

   always_comb begin
      ptr_d = ptr_q;
      if (hs) ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
   end

   // Signed compare reuses the unsigned comparator with both sign bits inverted.
   always_comb begin
      cmp_a = s1_a_q;
      cmp_b = s1_b_q;
      if (s1_op_q[0]) begin
         cmp_a[WIDTH-1] = ~s1_a_q[WIDTH-1];
         cmp_b[WIDTH-1] = ~s1_b_q[WIDTH-1];
      end
      cmp_lt = cmp_a < cmp_b;
      cmp_eq = s1_a_q == s1_b_q;
      unique case (s1_op_q)
         OP_GTU, OP_GTS: cmp_res = !cmp_lt && !cmp_eq;
         OP_LTU, OP_LTS: cmp_res = cmp_lt;
         OP_GEU, OP_GES: cmp_res = !cmp_lt;
         OP_LEU, OP_LES: cmp_res = cmp_lt || cmp_eq;
         default:        cmp_res = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q   <= '0;
         s1_v_q  <= 1'b0;
         s1_a_q  <= '0;
         s1_b_q  <= '0;
         s1_op_q <= OP_GTU;
         s1_id_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         if (hs) begin
            s1_v_q  <= 1'b1;
            s1_a_q  <= req_a[32'(gnt_idx)*WIDTH +: WIDTH];
            s1_b_q  <= req_b[32'(gnt_idx)*WIDTH +: WIDTH];
            s1_op_q <= cmp_op_e'(req_op[32'(gnt_idx)*3 +: 3]);
            s1_id_q <= gnt_idx;
         end else if (s1_v_q && s2_accept) begin
            s1_v_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_result_q <= 1'b0;
         rsp_eq_q     <= 1'b0;
         rsp_id_q     <= '0;
         done_cnt_q   <= '0;
      end else begin
         if (s1_v_q && s2_accept) begin
            rsp_valid_q  <= 1'b1;
            rsp_result_q <= cmp_res;
            rsp_eq_q     <= cmp_eq;
            rsp_id_q     <= s1_id_q;
         end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
         if (rsp_valid_q && rsp_ready) done_cnt_q <= done_cnt_q + 32'd1;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_eq     = rsp_eq_q;
   assign rsp_id     = rsp_id_q;
   assign busy       = s1_v_q || rsp_valid_q;
   assign done_cnt   = done_cnt_q;

endmodule

// File: doc/cmp_share_sched.md
# cmp_share_sched

Scheduler that shares one registered WIDTH-bit magnitude comparator (carry-chain compare unit) between NREQ requesters. Each requester submits two operands and a compare opcode over a valid/ready handshake. A round-robin arbiter feeds a two-stage pipeline (operand capture, compare). Results return on a single response channel tagged with the requester index. The block sits between the counter/threshold logic of several clients and the single compare resource.

## Interface
- NREQ, 4: number of requesters, ≥2
- WIDTH, 32: operand width, ≥2
- IDW, $clog2(NREQ): response id width (derived)

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  bit i: requester i has an op pending
- req_ready  out  NREQ  bit i: op i accepted this cycle; at most one bit high
- req_a  in  NREQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH]
- req_b  in  NREQ*WIDTH  operand B of requester i, same packing
- req_op  in  NREQ*3  opcode of requester i at [i*3 +: 3]
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  IDW  index of the requester that issued the op
- rsp_result  out  1  compare outcome
- rsp_eq  out  1  A == B
- busy  out  1  any pipeline stage occupied
- done_cnt  out  32  count of completed response handshakes

## Operation
- Opcodes: 0 gtu, 1 gts, 2 ltu, 3 lts, 4 geu, 5 ges, 6 leu, 7 les. Suffix u is unsigned. Suffix s is two's complement, with MSB as sign.
- Arbiter: round-robin priority pointer ptr, reset 0.
  - Grant goes to the first i with req_valid[i], searching from ptr upward mod NREQ.
  - req_ready[i] = grant[i] & s1_accept & rst_n. req_ready may depend combinationally on req_valid.
  - On handshake with requester g: ptr ← (g+1) mod NREQ. Without a handshake, ptr holds.
- Requesters hold valid, operands and opcode stable until their handshake. Dropping valid early is a protocol violation with undefined results.
- Stage 1 (s1): on handshake, latch A, B, op, id; s1_v ← 1.
- Stage 2 (s2): compute from s1 and register rsp_result, rsp_eq, rsp_id; rsp_valid ← 1.
- Flow control:
  - s2_accept = !rsp_valid | rsp_ready.
  - s1_accept = !s1_v | s2_accept.
  - s2 loads when s1_v & s2_accept. Otherwise, rsp_valid clears on a response handshake, and s2 holds while stalled.
  - s1_v clears when s1 moves to s2 and no new handshake occurs in the same cycle.
- Simultaneous drain and accept in one cycle is legal: one op per cycle in steady state.
- busy = s1_v | rsp_valid.
- done_cnt increments on rsp_valid & rsp_ready and wraps from 0xFFFFFFFF to 0.
- Reset (asserted at any time, including mid-operation):
  - Discard in-flight ops.
  - rsp_valid 0, rsp_id 0, rsp_result 0, rsp_eq 0, busy 0, done_cnt 0, ptr 0.
  - req_ready is all-zero while rst_n is low.

## Timing
- Latency: handshake at edge N → rsp_valid high after edge N+1, so the response is sampled at edge N+2.
- Throughput: one op per cycle while rsp_ready is high.
- Under backpressure at most 2 ops are in flight (s1 and s2). req_ready is all-zero while both stages are full and rsp_ready is low.
- Responses return in acceptance order.
- rsp_* are stable while rsp_valid & !rsp_ready.
- All outputs except req_ready are registered. req_ready is combinational from req_valid, ptr, stage state, rsp_ready and rst_n.
- Reset deassertion is synchronized externally. The first handshake is possible on the first edge with rst_n high.

## Test plan
- **Reset values:** pulse rst_n low while two ops are in flight and all req_valid are high → during reset, req_ready = 0 and rsp_valid = 0. After release, rsp_valid = 0, done_cnt = 0, busy = 0, and the first grant goes to requester 0.
- **Single op, unsigned vs signed:** requester 2 sends A = 0x00000001, B = 0xFFFFFFFF.
  - gtu → rsp_result 0, rsp_eq 0, rsp_id 2, two cycles after the handshake.
  - Repeat with gts → rsp_result 1.
- **Sign-boundary cases:**
  - A = B = 0x80000000: geu, ges, leu, les → 1; gtu, ltu → 0; rsp_eq 1.
  - A = 0x7FFFFFFF, B = 0x80000000: ltu → 1, lts → 0, gts → 1.
- **Round-robin fairness:** all four req_valid held high, rsp_ready = 1 → grants 0, 1, 2, 3, 0, 1 on consecutive cycles. rsp_id follows the same sequence, one response per cycle, and done_cnt = 6 after 6 responses.
- **Backpressure:** continuous requests, rsp_ready low for 5 cycles → exactly 2 ops are held and req_ready = 0 after the pipeline fills. After release, responses resume in order with no loss or duplication, and done_cnt matches the number of accepted ops.
- **Pointer skip and done_cnt wrap:**
  - Only requesters 1 and 3 valid, ptr = 2 → grant 3, then 1.
  - With done_cnt forced to 0xFFFFFFFF, one response → done_cnt = 0.
